// File: rtl/toy_uart_rx.sv
// UART 8N1 receiver: synchroniser, start/data/stop FSM and a small
// byte FIFO presented on a valid/ready stream.
module toy_uart_rx #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          rx_en,
    input  logic                          rx_i,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [AW-1:0]        PTR_ONE = 1;
    localparam logic [AW:0]          LVL_ONE = 1;
    localparam logic [AW:0]          LVL_FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cnt_nx;
    logic [DIV_WIDTH-1:0] div_lat;
    logic [DIV_WIDTH-1:0] div_nx;
    logic [DIV_WIDTH-1:0] half;
    logic [2:0]           idx;
    logic [2:0]           idx_nx;
    logic [7:0]           shift;
    logic [7:0]           shift_nx;

    logic rx_m;
    logic rx_s;
    logic rx_prev;
    logic fall;

    logic push;
    logic pop;
    logic full;
    logic ferr_nx;
    logic ovr_nx;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx_i;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;
    assign half = div_lat >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            div_lat   <= '0;
            idx       <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            div_lat   <= div_nx;
            idx       <= idx_nx;
            shift     <= shift_nx;
            frame_err <= ferr_nx;
            overrun   <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        div_nx   = div_lat;
        idx_nx   = idx;
        shift_nx = shift;
        push     = 1'b0;
        ferr_nx  = 1'b0;
        ovr_nx   = 1'b0;
        if (!rx_en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        div_nx   = baud_div;
                        cnt_nx   = '0;
                        state_nx = START;
                    end
                end
                START: begin
                    if (cnt == half) begin
                        cnt_nx = '0;
                        if (!rx_s) begin
                            idx_nx   = '0;
                            state_nx = DATA;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == div_lat) begin
                        shift_nx[idx] = rx_s;
                        cnt_nx        = '0;
                        if (idx == 3'd7) begin
                            state_nx = STOP;
                        end else begin
                            idx_nx = idx + 3'd1;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt == div_lat) begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                        // A pop in the same cycle frees the slot we need.
                        if (rx_s) begin
                            if (!full || pop) begin
                                push = 1'b1;
                            end else begin
                                ovr_nx = 1'b1;
                            end
                        end else begin
                            ferr_nx = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign full = (count == LVL_FULL);
    assign pop  = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
        end
    end

    assign rx_data    = mem[rd_ptr];
    assign rx_valid   = (count != '0);
    assign rx_busy    = (state != IDLE);
    assign fifo_level = count;

endmodule

// File: tb/tb_toy_uart_rx.sv
// Directed bench for toy_uart_rx: frames are driven bit by bit and the
// delivered stream, pulses and latency are checked against fixed values.
module tb_toy_uart_rx;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] baud_div = 12'd9;
    logic          rx_en = 1'b1;
    logic          rx_i = 1'b1;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b1;
    logic          frame_err;
    logic          overrun;
    logic          rx_busy;
    logic [2:0]    fifo_level;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_start = 0;

    logic [7:0] got [$];
    int   ferr_cnt = 0;
    int   ovr_cnt = 0;
    int   vcyc = 0;
    int   rise_cyc = 0;
    logic pv = 1'b0;

    int g0;
    int f0;
    int o0;
    int v0;

    logic [7:0] stream_b [10] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
                                 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hE1};

    toy_uart_rx #(
        .DIV_WIDTH (DW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_div  (baud_div),
        .rx_en     (rx_en),
        .rx_i      (rx_i),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_valid) vcyc++;
            if (rx_valid && !pv) rise_cyc = cyc;
        end
        pv = rx_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop,
                        input int d);
        rx_i = 1'b0;
        last_start = cyc;
        repeat (d + 1) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (d + 1) tick();
        end
        rx_i = stop;
        repeat (d + 1) tick();
        rx_i = 1'b1;
    endtask

    task automatic mark();
        g0 = got.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        v0 = vcyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        rst_n = 1'b1;
        repeat (4) tick();

        // basic 0xA5 at divider 9
        baud_div = 12'd9;
        rx_ready = 1'b1;
        mark();
        send(8'hA5, 1'b1, 9);
        repeat (5) tick();
        check("basic_cnt", 32'(got.size() - g0), 32'd1);
        check("basic_data", 32'(got[g0]), 32'hA5);
        check("basic_lat", 32'(rise_cyc - last_start), 32'd98);
        check("basic_vcyc", 32'(vcyc - v0), 32'd1);
        check("basic_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("basic_ovr", 32'(ovr_cnt - o0), 32'd0);

        // glitch shorter than half a bit
        baud_div = 12'd15;
        mark();
        rx_i = 1'b0;
        repeat (3) tick();
        rx_i = 1'b1;
        tick();
        check("glitch_busy_on", 32'(rx_busy), 32'd1);
        repeat (20) tick();
        check("glitch_busy_off", 32'(rx_busy), 32'd0);
        check("glitch_level", 32'(fifo_level), 32'd0);
        check("glitch_cnt", 32'(got.size() - g0), 32'd0);

        // framing error then good byte
        baud_div = 12'd9;
        mark();
        send(8'h3C, 1'b0, 9);
        repeat (5) tick();
        check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_level", 32'(fifo_level), 32'd0);
        check("ferr_nopush", 32'(got.size() - g0), 32'd0);
        send(8'h11, 1'b1, 9);
        repeat (5) tick();
        check("ferr_next", 32'(got[g0]), 32'h11);
        check("ferr_once", 32'(ferr_cnt - f0), 32'd1);

        // overrun with consumer stalled
        rx_ready = 1'b0;
        mark();
        for (int b = 1; b <= 5; b++) send(8'(b), 1'b1, 9);
        repeat (5) tick();
        check("ovr_level", 32'(fifo_level), 32'd4);
        check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_head", 32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        repeat (4) tick();
        rx_ready = 1'b0;
        check("ovr_drain", 32'(fifo_level), 32'd0);
        check("ovr_cnt", 32'(got.size() - g0), 32'd4);
        for (int i = 0; i < 4; i++)
            check("ovr_order", 32'(got[g0 + i]), 32'(i + 1));

        // full FIFO with a pop on the 5th stop sample cycle
        mark();
        for (int b = 1; b <= 4; b++) send(8'(b), 1'b1, 9);
        fork
            send(8'h05, 1'b1, 9);
            begin
                repeat (97) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        repeat (5) tick();
        check("fp_ovr", 32'(ovr_cnt - o0), 32'd0);
        check("fp_level", 32'(fifo_level), 32'd4);
        check("fp_head", 32'(rx_data), 32'h02);
        rx_ready = 1'b1;
        repeat (4) tick();
        check("fp_cnt", 32'(got.size() - g0), 32'd5);
        check("fp_last", 32'(got[g0 + 4]), 32'h05);
        check("fp_empty", 32'(fifo_level), 32'd0);

        // disable after bit 3
        mark();
        fork
            send(8'h5A, 1'b1, 9);
            begin
                repeat (50) tick();
                check("dis_busy_pre", 32'(rx_busy), 32'd1);
                rx_en = 1'b0;
                tick();
                check("dis_busy", 32'(rx_busy), 32'd0);
            end
        join
        rx_en = 1'b1;
        repeat (5) tick();
        check("dis_nopush", 32'(got.size() - g0), 32'd0);
        check("dis_noerr", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);
        send(8'h5A, 1'b1, 9);
        repeat (5) tick();
        check("dis_reen", 32'(got[g0]), 32'h5A);

        // async reset mid-frame with a byte buffered
        rx_ready = 1'b0;
        send(8'h77, 1'b1, 9);
        repeat (3) tick();
        check("rstm_pre_valid", 32'(rx_valid), 32'd1);
        fork
            send(8'h99, 1'b1, 9);
            begin
                repeat (30) tick();
                check("rstm_pre_busy", 32'(rx_busy), 32'd1);
                rst_n = 1'b0;
                #1;
                check("rstm_busy", 32'(rx_busy), 32'd0);
                check("rstm_valid", 32'(rx_valid), 32'd0);
                check("rstm_level", 32'(fifo_level), 32'd0);
                check("rstm_data", 32'(rx_data), 32'h0);
                check("rstm_pulses", 32'({frame_err, overrun}), 32'd0);
            end
        join
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("rstm_after", 32'({rx_busy, fifo_level}), 32'd0);
        rx_ready = 1'b1;

        // minimum divider
        baud_div = 12'd3;
        mark();
        send(8'hFF, 1'b1, 3);
        send(8'h00, 1'b1, 3);
        repeat (5) tick();
        check("min_cnt", 32'(got.size() - g0), 32'd2);
        check("min_ff", 32'(got[g0]), 32'hFF);
        check("min_00", 32'(got[g0 + 1]), 32'h00);

        // pointer wrap over a 10 byte stream
        mark();
        for (int i = 0; i < 10; i++) send(stream_b[i], 1'b1, 3);
        repeat (5) tick();
        check("wrap_cnt", 32'(got.size() - g0), 32'd10);
        for (int i = 0; i < 10; i++)
            check("wrap_order", 32'(got[g0 + i]), 32'(stream_b[i]));

        // all-ones divider, changed mid-frame without effect
        baud_div = 12'hFFF;
        mark();
        fork
            send(8'h81, 1'b1, 4095);
            begin
                repeat (1000) tick();
                baud_div = 12'd3;
            end
        join
        repeat (5) tick();
        check("max_cnt", 32'(got.size() - g0), 32'd1);
        check("max_data", 32'(got[g0]), 32'h81);
        check("max_lat", 32'(rise_cyc - last_start), 32'd38915);
        check("max_noerr", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/toy_uart_rx.md
Name: toy_uart_rx

Overview:
UART receive engine for the peripheral subsystem. It deserialises the serial line driven into the SoC (the counterpart of the peripheral TX path) into bytes. Received bytes are buffered in a small FIFO and presented on a valid/ready stream to the peripheral register block. Format is fixed 8N1, LSB first, with a runtime-programmable bit period.

Parameters:
DIV_WIDTH, 16, width of the bit-period divider input and counter.
FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  core clock; sole clock domain.
rst_n  input  1  asynchronous active-low reset.
baud_div  input  DIV_WIDTH  clk cycles per UART bit, minus 1; minimum legal value 3; sampled only in IDLE.
rx_en  input  1  receiver enable; 0 forces IDLE and drops any frame in progress.
rx_i  input  1  serial line, asynchronous, idle high.
rx_data  output  8  FIFO head byte.
rx_valid  output  1  FIFO non-empty.
rx_ready  input  1  consumer accepts the head when rx_valid&&rx_ready.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: byte completed while FIFO full; byte dropped.
rx_busy  output  1  FSM not in IDLE.
fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0, fifo_level=0, FSM=IDLE, FIFO pointers=0. Synchroniser flops reset to 1.
- rx_i passes through a 2-flop synchroniser (rx_s). Start-edge detection uses rx_s and a registered previous value.
- Divider: bit_cnt counts 0..div_lat, where div_lat is baud_div latched on leaving IDLE. half = div_lat>>1.
- IDLE: rx_busy=0. On rx_en && falling edge of rx_s: latch div_lat, clear the counter, go to START.
- START: when counter==half, sample rx_s. If 0, clear the counter, set bit index 0, go to DATA. If 1 (glitch), return to IDLE with no output.
- DATA: when counter==div_lat, sample rx_s into shift[bit index], where bit 0 is received first. Clear the counter. After bit 7 go to STOP.
- STOP: when counter==div_lat, sample rx_s.
  - 1: push the byte if the FIFO is not full; otherwise pulse overrun and drop the byte.
  - 0: pulse frame_err and discard the byte (not pushed).
  - In both cases go to IDLE.
- Samples land mid-bit: START at half, then every div_lat+1 cycles.
- The next start edge is accepted on the cycle after STOP completes. Back-to-back frames with no idle gap must be received.
- rx_en=0 in any state: next cycle FSM=IDLE, counter cleared, no push and no pulses. FIFO contents are retained.
- FIFO: push happens in the STOP cycle and pop on rx_valid&&rx_ready.
  - Simultaneous push and pop with the FIFO full is legal: the pop frees a slot, both occur, and there is no overrun.
  - Simultaneous push and pop with the FIFO empty: the pushed byte is written and becomes rx_valid the next cycle. There is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level updates the cycle after the event.
- Latency: rx_valid rises 1 cycle after the STOP sample cycle, when the FIFO was empty.
- rx_data is stable while rx_valid && !rx_ready.
- baud_div changes while busy have no effect until the next frame.
- Asynchronous reset mid-frame: all state is cleared immediately. After reset deassertion, rx_i must be seen high before a falling edge counts, because the synchroniser resets high.

Test Plan:
- Basic receive: baud_div=9, send 0xA5 8N1, rx_ready=1. Required: rx_data=0xA5 and rx_valid high for 1 cycle, 1 cycle after the STOP sample; no error pulses.
- Glitch rejection: baud_div=15, drive rx_i low for 3 cycles then high. Required: FSM returns to IDLE, no push, fifo_level stays 0.
- Framing error: send 0x3C with the stop bit low. Required: frame_err pulses exactly 1 cycle, fifo_level remains 0, and a following valid 0x11 is received correctly.
- Overrun and full+pop: hold rx_ready=0 and send 0x01..0x05 back-to-back.
  - Required: fifo_level=4, overrun pulses once, and bytes pop as 0x01..0x04.
  - Repeat with a single pop aligned to the 5th STOP cycle: required no overrun and 0x05 stored.
- Disable and reset mid-frame:
  - Deassert rx_en after bit 3 of 0x5A: required rx_busy=0 the next cycle, no output.
  - Re-enable and send 0x5A: required 0x5A received.
  - Assert rst_n low mid-frame: required all outputs at reset values immediately.
- Divider extremes and wrap: receive 0xFF and 0x00 at baud_div=3, and 0x81 at baud_div=65535.
  - Required: all bytes correct.
  - Stream 10 bytes with rx_ready=1 to exercise pointer wrap; required in-order delivery.
